// File: rtl/mem_addr_seq.sv
// mem_addr_seq: selects one of N_SRC address sources, checks it for
// alignment and range, registers it as the memory address and sequences a
// fixed-latency access with a busy/done handshake and a sticky fault.
//
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   sel          - source index, sampled on an accepted request
//   src_flat     - N_SRC concatenated W-bit sources (source i at [i*W +: W])
//   access_req   - start an access (sampled in IDLE only)
//   access_size  - 00 word, 01 halfword, 10 byte, 11 treated as word
//   fault_clr    - clears the sticky fault, returns to IDLE
//   mem_addr     - registered memory address
//   busy / done  - access in progress / one-cycle completion pulse
//   fault        - sticky fault flag
//   fault_code   - 00 none, 01 misaligned, 10 out of range, 11 invalid select
//   bad_addr     - address that caused the fault (0 for invalid select)
module mem_addr_seq #(
  parameter int unsigned  W          = 32,
  parameter int unsigned  N_SRC      = 5,
  parameter int unsigned  SEL_W      = 3,
  parameter int unsigned  LAT        = 1,
  parameter logic [W-1:0] ADDR_LIMIT = W'(32'h0000_00FF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_SRC*W-1:0] src_flat,
  input  logic               access_req,
  input  logic [1:0]         access_size,
  input  logic               fault_clr,
  output logic [W-1:0]       mem_addr,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [W-1:0]       bad_addr
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     cand;
  logic             sel_bad, misal, range_bad;
  logic [W-1:0]     mem_addr_d, bad_addr_d;
  logic             busy_d, done_d, fault_d;
  logic [1:0]       fault_code_d;

  // Source mux; an out-of-range select yields zero and is flagged separately.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) cand = src_flat[i*W +: W];
    end
  end

  // Candidate checks; priority is resolved in the output logic.
  always_comb begin
    sel_bad   = (32'(sel) >= N_SRC);
    range_bad = (cand > ADDR_LIMIT);
    case (access_size)
      2'b01:   misal = cand[0];
      2'b10:   misal = 1'b0;
      default: misal = (cand[1:0] != 2'b00);
    endcase
  end

  // State register plus registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      bad_addr   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr   <= mem_addr_d;
      busy       <= busy_d;
      done       <= done_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
      bad_addr   <= bad_addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (access_req) begin
          state_d = (sel_bad || misal || range_bad) ? S_FAULT : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and latency counter.
  always_comb begin
    mem_addr_d   = mem_addr;
    busy_d       = busy;
    done_d       = 1'b0;
    fault_d      = fault;
    fault_code_d = fault_code;
    bad_addr_d   = bad_addr;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access_req) begin
          if (sel_bad) begin
            fault_d      = 1'b1;
            fault_code_d = 2'b11;
            bad_addr_d   = '0;
          end else if (misal) begin
            fault_d      = 1'b1;
            fault_code_d = 2'b01;
            bad_addr_d   = cand;
          end else if (range_bad) begin
            fault_d      = 1'b1;
            fault_code_d = 2'b10;
            bad_addr_d   = cand;
          end else begin
            mem_addr_d = cand;
            busy_d     = 1'b1;
            cnt_d      = CNT_W'(LAT - 1);
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          fault_d      = 1'b0;
          fault_code_d = 2'b00;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: a LAT=1 instance driven from a vector table with a
// scoreboard queue, and a LAT=3 instance for back-to-back and mid-access
// reset sequences.
module tb_mem_addr_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned SW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] src_flat;
  logic           access_req;
  logic [1:0]     access_size;
  logic           fault_clr;
  logic [W-1:0]   src [N];

  logic [W-1:0] mem_addr1, bad_addr1, mem_addr3, bad_addr3;
  logic         busy1, done1, fault1, busy3, done3, fault3;
  logic [1:0]   fault_code1, fault_code3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < N; i++) src_flat[i*W +: W] = src[i];
  end

  mem_addr_seq #(.W(W), .N_SRC(N), .SEL_W(SW), .LAT(1), .ADDR_LIMIT(32'h0000_00FF)) dut1 (
    .clk(clk), .reset(reset), .sel(sel), .src_flat(src_flat),
    .access_req(access_req), .access_size(access_size), .fault_clr(fault_clr),
    .mem_addr(mem_addr1), .busy(busy1), .done(done1), .fault(fault1),
    .fault_code(fault_code1), .bad_addr(bad_addr1)
  );

  mem_addr_seq #(.W(W), .N_SRC(N), .SEL_W(SW), .LAT(3), .ADDR_LIMIT(32'h0000_00FF)) dut3 (
    .clk(clk), .reset(reset), .sel(sel), .src_flat(src_flat),
    .access_req(access_req), .access_size(access_size), .fault_clr(fault_clr),
    .mem_addr(mem_addr3), .busy(busy3), .done(done3), .fault(fault3),
    .fault_code(fault_code3), .bad_addr(bad_addr3)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  size;
    logic [31:0] val;
    logic        exp_fault;
    logic [1:0]  exp_code;
    logic [31:0] exp_bad;
  } vec_t;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [31:0] bad;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_addr3"}, mem_addr3, 32'h0);
    chk({tag, " busy3"}, 32'(busy3), 32'h0);
    chk({tag, " done3"}, 32'(done3), 32'h0);
    chk({tag, " fault3"}, 32'(fault3), 32'h0);
    chk({tag, " code3"}, 32'(fault_code3), 32'h0);
    chk({tag, " bad3"}, bad_addr3, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    exp_t        e;
    logic [31:0] model_addr;
    logic [31:0] model_bad;
    int          w;

    reset = 1'b1; sel = '0; access_req = 1'b0; access_size = 2'b00; fault_clr = 1'b0;
    src[0] = 32'h10; src[1] = 32'h13; src[2] = 32'h100; src[3] = 32'h20; src[4] = 32'h80;

    //          sel    size   val           flt   code   bad
    vecs[0]  = '{3'd0, 2'b00, 32'h0000_0010, 1'b0, 2'b00, 32'h0};
    vecs[1]  = '{3'd1, 2'b01, 32'h0000_0013, 1'b1, 2'b01, 32'h13};
    vecs[2]  = '{3'd2, 2'b00, 32'h0000_0100, 1'b1, 2'b10, 32'h100};
    vecs[3]  = '{3'd2, 2'b10, 32'h0000_00FF, 1'b0, 2'b00, 32'h0};
    vecs[4]  = '{3'd5, 2'b00, 32'h0000_0000, 1'b1, 2'b11, 32'h0};
    vecs[5]  = '{3'd7, 2'b10, 32'h0000_0000, 1'b1, 2'b11, 32'h0};
    vecs[6]  = '{3'd3, 2'b01, 32'h0000_0022, 1'b0, 2'b00, 32'h0};
    vecs[7]  = '{3'd4, 2'b00, 32'h0000_0102, 1'b1, 2'b01, 32'h102};
    vecs[8]  = '{3'd0, 2'b10, 32'h0000_0101, 1'b1, 2'b10, 32'h101};
    vecs[9]  = '{3'd1, 2'b11, 32'h0000_0006, 1'b1, 2'b01, 32'h6};
    vecs[10] = '{3'd0, 2'b00, 32'h0000_00FC, 1'b0, 2'b00, 32'h0};
    vecs[11] = '{3'd1, 2'b01, 32'h0000_0100, 1'b1, 2'b10, 32'h100};

    #1;
    chk_all_zero("reset_async");
    tick();
    reset = 1'b0;
    chk("reset mem_addr1", mem_addr1, 32'h0);
    chk("reset busy1", 32'(busy1), 32'h0);
    chk("reset fault1", 32'(fault1), 32'h0);
    model_addr = 32'h0;
    model_bad  = 32'h0;

    // Table-driven requests on the LAT=1 instance.
    for (int i = 0; i < 12; i++) begin
      if (32'(vecs[i].sel) < N) src[vecs[i].sel] = vecs[i].val;
      sel = vecs[i].sel; access_size = vecs[i].size; access_req = 1'b1;
      e.is_fault = vecs[i].exp_fault;
      e.code     = vecs[i].exp_fault ? vecs[i].exp_code : 2'b00;
      e.bad      = vecs[i].exp_fault ? vecs[i].exp_bad : model_bad;
      e.addr     = vecs[i].exp_fault ? model_addr : vecs[i].val;
      sbq.push_back(e);
      if (vecs[i].exp_fault) model_bad = vecs[i].exp_bad;
      else model_addr = vecs[i].val;
      tick();
      access_req = 1'b0;
      w = 0;
      while (!(busy1 || fault1) && w < 5) begin
        tick();
        w++;
      end
      if (!(busy1 || fault1)) begin
        n_vec++; n_err++;
        $display("FAIL vec%0d timeout: no busy/fault response", i);
      end
      e = sbq.pop_front();
      chk($sformatf("vec%0d fault", i), 32'(fault1), 32'(e.is_fault));
      chk($sformatf("vec%0d code", i), 32'(fault_code1), 32'(e.code));
      chk($sformatf("vec%0d bad_addr", i), bad_addr1, e.bad);
      chk($sformatf("vec%0d mem_addr", i), mem_addr1, e.addr);
      chk($sformatf("vec%0d busy", i), 32'(busy1), 32'(!e.is_fault));
      chk($sformatf("vec%0d done", i), 32'(done1), 32'h0);
      if (!e.is_fault) begin
        tick();
        chk($sformatf("vec%0d done pulse", i), 32'(done1), 32'h1);
        chk($sformatf("vec%0d busy end", i), 32'(busy1), 32'h0);
        tick();
        chk($sformatf("vec%0d done drop", i), 32'(done1), 32'h0);
      end else begin
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk($sformatf("vec%0d clr fault", i), 32'(fault1), 32'h0);
        chk($sformatf("vec%0d clr code", i), 32'(fault_code1), 32'h0);
        chk($sformatf("vec%0d clr bad kept", i), bad_addr1, model_bad);
      end
    end

    // Requests are ignored while faulted, including alongside fault_clr.
    src[1] = 32'h13; src[0] = 32'h40;
    sel = 3'd1; access_size = 2'b01; access_req = 1'b1;
    tick();
    chk("seqA fault", 32'(fault_code1), 32'h1);
    sel = 3'd0; access_size = 2'b00;
    tick();
    chk("seqA ignored fault", 32'(fault1), 32'h1);
    chk("seqA ignored busy", 32'(busy1), 32'h0);
    chk("seqA mem_addr held", mem_addr1, model_addr);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0; access_req = 1'b0;
    chk("seqA clr fault", 32'(fault1), 32'h0);
    chk("seqA clr busy", 32'(busy1), 32'h0);
    tick();
    chk("seqA still idle", 32'(busy1), 32'h0);
    chk("seqA mem_addr", mem_addr1, model_addr);

    // LAT=3 back-to-back, second request issued in the done cycle.
    do_reset();
    chk_all_zero("seqB reset");
    src[3] = 32'h20; src[4] = 32'h80;
    sel = 3'd3; access_size = 2'b00; access_req = 1'b1;
    tick();
    access_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk($sformatf("seqB1 busy c%0d", c), 32'(busy3), 32'h1);
      chk($sformatf("seqB1 done c%0d", c), 32'(done3), 32'h0);
      chk($sformatf("seqB1 addr c%0d", c), mem_addr3, 32'h20);
    end
    tick();
    chk("seqB1 done", 32'(done3), 32'h1);
    chk("seqB1 busy end", 32'(busy3), 32'h0);
    sel = 3'd4; access_req = 1'b1;
    tick();
    access_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk($sformatf("seqB2 busy c%0d", c), 32'(busy3), 32'h1);
      chk($sformatf("seqB2 done c%0d", c), 32'(done3), 32'h0);
      chk($sformatf("seqB2 addr c%0d", c), mem_addr3, 32'h80);
    end
    tick();
    chk("seqB2 done", 32'(done3), 32'h1);
    chk("seqB2 busy end", 32'(busy3), 32'h0);
    tick();
    chk("seqB2 done drop", 32'(done3), 32'h0);

    // Reset asserted in the second ACCESS cycle, then a clean access.
    sel = 3'd3; access_req = 1'b1;
    tick();
    access_req = 1'b0;
    chk("seqC busy", 32'(busy3), 32'h1);
    tick();
    chk("seqC busy 2nd", 32'(busy3), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("seqC async");
    tick();
    tick();
    chk("seqC no done", 32'(done3), 32'h0);
    reset = 1'b0;
    sel = 3'd4; access_req = 1'b1;
    tick();
    access_req = 1'b0;
    chk("seqC2 busy", 32'(busy3), 32'h1);
    chk("seqC2 addr", mem_addr3, 32'h80);
    w = 0;
    while (!done3 && w < 10) begin
      tick();
      w++;
    end
    chk("seqC2 done", 32'(done3), 32'h1);
    chk("seqC2 latency", 32'(w), 32'd3);
    chk("seqC2 fault", 32'(fault3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
